// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: FSM state encoding and counter sizing.
package mem_stage_pkg;

  localparam int MEM_ST_LEN = 1;

  typedef enum logic [MEM_ST_LEN-1:0] {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_st_e;

  // Counter must hold WAIT_CYCLES without wrapping; never narrower than 1 bit.
  function automatic int cnt_width(int wc);
    return (wc < 1) ? 1 : $clog2(wc + 1);
  endfunction

endpackage

// File: rtl/mem_stage_data_mem.sv
// Word-addressed data memory: asynchronous read, synchronous write, no reset of contents.
module data_mem #(
  parameter int WORD_LEN = 32,
  parameter int DEPTH    = 1024,
  localparam int IDX_W   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [IDX_W-1:0]    addr,
  input  logic [WORD_LEN-1:0] wdata,
  output logic [WORD_LEN-1:0] rdata
);

  logic [WORD_LEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: load/store into data_mem with WAIT_CYCLES of upstream freeze per access.
// Optional address fault checking is enabled by defining MEM_ADDR_CHK_EN (adds the mem_err port).
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int WORD_LEN    = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int BASE_ADDR   = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MEM_R_EN,
  input  logic                MEM_W_EN,
  input  logic [WORD_LEN-1:0] ALU_res,
  input  logic [WORD_LEN-1:0] ST_value,
  output logic [WORD_LEN-1:0] read_value,
  output logic                freeze
`ifdef MEM_ADDR_CHK_EN
  ,
  output logic                mem_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(WAIT_CYCLES);

  mem_st_e             state;
  logic [CNT_W-1:0]    cnt;
  logic                req, done, fault, we;
  logic [WORD_LEN-1:0] offset, rdata;
  logic [IDX_W-1:0]    idx;

  assign req    = MEM_R_EN | MEM_W_EN;
  assign offset = ALU_res - WORD_LEN'(BASE_ADDR);
  assign idx    = offset[IDX_W+1:2];

  // Byte-offset bits and above-depth bits only matter to the fault check.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{offset[1:0], offset[WORD_LEN-1:IDX_W+2]};

`ifdef MEM_ADDR_CHK_EN
  assign fault = rst & req & (state == MEM_IDLE) &
                 ((ALU_res[1:0] != 2'b00) |
                  (ALU_res < WORD_LEN'(BASE_ADDR)) |
                  (|offset[WORD_LEN-1:IDX_W+2]));
  assign mem_err = fault;
`else
  assign fault = 1'b0;
`endif

  assign done = ((state == MEM_WAIT) && (cnt == CNT_W'(WAIT_CYCLES))) ||
                ((state == MEM_IDLE) && req && (WAIT_CYCLES == 0));

  // Everything is gated by rst so a reset mid-access drops the pending store.
  assign freeze     = rst & req & ~done & ~fault;
  assign we         = rst & MEM_W_EN & done & ~fault;
  assign read_value = (rst & MEM_R_EN & done & ~fault) ? rdata : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= MEM_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MEM_IDLE: begin
          if (req && !fault && (WAIT_CYCLES != 0)) begin
            state <= MEM_WAIT;
            cnt   <= CNT_W'(1);
          end
        end
        MEM_WAIT: begin
          // A dropped request is a flush: leave without committing.
          if (!req || (cnt == CNT_W'(WAIT_CYCLES))) begin
            state <= MEM_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= MEM_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  data_mem #(
    .WORD_LEN(WORD_LEN),
    .DEPTH   (DEPTH)
  ) u_data_mem (
    .clk  (clk),
    .we   (we),
    .addr (idx),
    .wdata(ST_value),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: per-cycle vector table on a WAIT_CYCLES=2 instance,
// hand sequences for a single-cycle instance and the optional address-fault path.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        r2 = 1'b0, w2 = 1'b0;
  logic [31:0] a2 = '0, s2 = '0, rv2;
  logic        frz2;
  logic        r0 = 1'b0, w0 = 1'b0;
  logic [31:0] a0 = '0, s0 = '0, rv0;
  logic        frz0;
`ifdef MEM_ADDR_CHK_EN
  logic        err2, err0;
`endif

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_stage #(.WORD_LEN(32), .DEPTH(1024), .WAIT_CYCLES(2), .BASE_ADDR(1024)) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(r2), .MEM_W_EN(w2), .ALU_res(a2), .ST_value(s2),
    .read_value(rv2), .freeze(frz2)
`ifdef MEM_ADDR_CHK_EN
    , .mem_err(err2)
`endif
  );

  mem_stage #(.WORD_LEN(32), .DEPTH(1024), .WAIT_CYCLES(0), .BASE_ADDR(1024)) dut0 (
    .clk(clk), .rst(rst), .MEM_R_EN(r0), .MEM_W_EN(w0), .ALU_res(a0), .ST_value(s0),
    .read_value(rv0), .freeze(frz0)
`ifdef MEM_ADDR_CHK_EN
    , .mem_err(err0)
`endif
  );

  typedef struct {
    logic        rst_n;
    logic        r, w;
    logic [31:0] addr, st;
    logic        exp_frz;
    logic [31:0] exp_rv;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic rn, input logic r, input logic w, input logic [31:0] addr,
                     input logic [31:0] st, input logic ef, input logic [31:0] erv);
    vec_t v;
    v.rst_n = rn; v.r = r; v.w = w; v.addr = addr; v.st = st; v.exp_frz = ef; v.exp_rv = erv;
    tv.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  initial begin
    // reset with both enables high: nothing visible
    add(0, 1, 1, 1024, 32'h0, 0, 0);
    add(0, 1, 1, 1024, 32'h0, 0, 0);
    // store DEADBEEF @1024, then load it back
    add(1, 0, 1, 1024, 32'hDEADBEEF, 1, 0);
    add(1, 0, 1, 1024, 32'hDEADBEEF, 1, 0);
    add(1, 0, 1, 1024, 32'hDEADBEEF, 0, 0);
    add(1, 1, 0, 1024, 32'h0, 1, 0);
    add(1, 1, 0, 1024, 32'h0, 1, 0);
    add(1, 1, 0, 1024, 32'h0, 0, 32'hDEADBEEF);
    add(1, 0, 0, 0, 32'h0, 0, 0);
    // flush: old value 0x22 survives a dropped store of 0x11
    add(1, 0, 1, 1032, 32'h22, 1, 0);
    add(1, 0, 1, 1032, 32'h22, 1, 0);
    add(1, 0, 1, 1032, 32'h22, 0, 0);
    add(1, 0, 1, 1032, 32'h11, 1, 0);
    add(1, 0, 0, 0, 32'h0, 0, 0);
    add(1, 1, 0, 1032, 32'h0, 1, 0);
    add(1, 1, 0, 1032, 32'h0, 1, 0);
    add(1, 1, 0, 1032, 32'h0, 0, 32'h22);
    // both enables: behaves as store, returns pre-store data
    add(1, 0, 1, 1040, 32'h5, 1, 0);
    add(1, 0, 1, 1040, 32'h5, 1, 0);
    add(1, 0, 1, 1040, 32'h5, 0, 0);
    add(1, 1, 1, 1040, 32'h9, 1, 0);
    add(1, 1, 1, 1040, 32'h9, 1, 0);
    add(1, 1, 1, 1040, 32'h9, 0, 32'h5);
    add(1, 1, 0, 1040, 32'h0, 1, 0);
    add(1, 1, 0, 1040, 32'h0, 1, 0);
    add(1, 1, 0, 1040, 32'h0, 0, 32'h9);
    // reset on the completion cycle of a store drops it
    add(1, 0, 1, 1036, 32'hAA, 1, 0);
    add(1, 0, 1, 1036, 32'hAA, 1, 0);
    add(1, 0, 1, 1036, 32'hAA, 0, 0);
    add(1, 0, 1, 1036, 32'hBB, 1, 0);
    add(1, 0, 1, 1036, 32'hBB, 1, 0);
    add(0, 0, 1, 1036, 32'hBB, 0, 0);
    add(1, 1, 0, 1036, 32'h0, 1, 0);
    add(1, 1, 0, 1036, 32'h0, 1, 0);
    add(1, 1, 0, 1036, 32'h0, 0, 32'hAA);
    add(1, 0, 0, 0, 32'h0, 0, 0);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      rst = tv[i].rst_n; r2 = tv[i].r; w2 = tv[i].w; a2 = tv[i].addr; s2 = tv[i].st;
      #1;
      check("freeze", i, {31'b0, frz2}, {31'b0, tv[i].exp_frz});
      check("read_value", i, rv2, tv[i].exp_rv);
    end

    // single-cycle instance: store then load on consecutive cycles
    @(negedge clk); w0 = 1; r0 = 0; a0 = 1028; s0 = 32'h1234_5678; #1;
    check("wc0_store_freeze", 0, {31'b0, frz0}, 32'h0);
    check("wc0_store_rv", 0, rv0, 32'h0);
    @(negedge clk); w0 = 0; r0 = 1; a0 = 1028; #1;
    check("wc0_load_freeze", 1, {31'b0, frz0}, 32'h0);
    check("wc0_load_rv", 1, rv0, 32'h1234_5678);
`ifndef MEM_ADDR_CHK_EN
    // index wraps mod DEPTH and byte offset is ignored
    @(negedge clk); a0 = 1028 + 4 * 1024; #1;
    check("wc0_wrap_rv", 2, rv0, 32'h1234_5678);
    @(negedge clk); a0 = 1030; #1;
    check("wc0_lowbits_rv", 3, rv0, 32'h1234_5678);
`endif
    @(negedge clk); r0 = 0; #1;
    check("wc0_idle_rv", 4, rv0, 32'h0);

`ifdef MEM_ADDR_CHK_EN
    // misaligned load faults for one cycle without freezing
    @(negedge clk); r2 = 1; w2 = 0; a2 = 1026; #1;
    check("chk_mis_err", 0, {31'b0, err2}, 32'h1);
    check("chk_mis_freeze", 0, {31'b0, frz2}, 32'h0);
    check("chk_mis_rv", 0, rv2, 32'h0);
    @(negedge clk); r2 = 0; #1;
    check("chk_idle_err", 1, {31'b0, err2}, 32'h0);
    // faulting store below base must not commit
    @(negedge clk); w2 = 1; a2 = 1020; s2 = 32'h77; #1;
    check("chk_low_err", 2, {31'b0, err2}, 32'h1);
    check("chk_low_freeze", 2, {31'b0, frz2}, 32'h0);
    @(negedge clk); w2 = 0; r2 = 1; a2 = 1024; #1;
    check("chk_ok_err", 3, {31'b0, err2}, 32'h0);
    check("chk_ok_freeze", 3, {31'b0, frz2}, 32'h1);
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("chk_ok_rv", 4, rv2, 32'hDEADBEEF);
    @(negedge clk); r2 = 0; #1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
